// File: rtl/fpdiv_ctrl.sv
// Sequencing FSM for the Goldschmidt divider datapath: one initial-approximation
// phase, N_ITER two-cycle refinement iterations, then a one-cycle done pulse.
module fpdiv_ctrl #(
    parameter int unsigned N_ITER = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       enA,
    output logic       enB,
    output logic       enC
);

    localparam logic [3:0] LastIter = 4'(N_ITER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInitN,
        StInitD,
        StIterN,
        StIterD,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] iter_q, iter_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            iter_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        unique case (state_q)
            StIdle: begin
                iter_d = 4'd0;
                if (start) begin
                    state_d = StInitN;
                end
            end
            StInitN: state_d = StInitD;
            StInitD: state_d = StIterN;
            StIterN: state_d = StIterD;
            StIterD: begin
                iter_d  = iter_q + 4'd1;
                state_d = (iter_q < LastIter) ? StIterN : StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        busy     = 1'b1;
        done     = 1'b0;
        sel_muxa = 2'b00;
        sel_muxb = 2'b00;
        enA      = 1'b0;
        enB      = 1'b0;
        enC      = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StInitN: begin
                sel_muxa = 2'b10;
                sel_muxb = 2'b01;
                enC      = 1'b1;
            end
            StInitD: begin
                sel_muxa = 2'b10;
                sel_muxb = 2'b00;
                enA      = 1'b1;
                enB      = 1'b1;
            end
            StIterN: begin
                sel_muxb = 2'b11;
                enC      = 1'b1;
            end
            StIterD: begin
                sel_muxb = 2'b10;
                enA      = 1'b1;
                enB      = 1'b1;
            end
            StDone:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: a per-operation schedule model pushes the
// expected output vector for every cycle; a negedge monitor pops and compares.
module tb_fpdiv_ctrl;

    localparam int unsigned NIter  = 5;
    localparam int unsigned Period = 2 * NIter + 4;

    // {busy, done, sel_muxa, sel_muxb, enA, enB, enC}
    localparam logic [8:0] VIdle  = 9'b0_0_00_00_000;
    localparam logic [8:0] VInitN = 9'b1_0_10_01_001;
    localparam logic [8:0] VInitD = 9'b1_0_10_00_110;
    localparam logic [8:0] VIterN = 9'b1_0_00_11_001;
    localparam logic [8:0] VIterD = 9'b1_0_00_10_110;
    localparam logic [8:0] VDone  = 9'b1_1_00_00_000;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, enA, enB, enC;
    logic [1:0] sel_muxa, sel_muxb;

    fpdiv_ctrl #(.N_ITER(NIter)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sel_muxa (sel_muxa),
        .sel_muxb (sel_muxb),
        .enA      (enA),
        .enB      (enB),
        .enC      (enC)
    );

    always #5 clock = ~clock;

    logic [8:0] exp_q[$];
    logic [8:0] plan[$];
    logic       cur_idle;
    logic       mon_en = 1'b0;
    logic       b2b_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_done = -1;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: an accepted start expands to the full per-cycle schedule.
    task automatic model_step(input logic r, input logic s);
        logic [8:0] nxt;
        if (r) begin
            plan.delete();
            nxt = VIdle;
        end else if (cur_idle && s) begin
            plan.push_back(VInitN);
            plan.push_back(VInitD);
            for (int i = 0; i < int'(NIter); i++) begin
                plan.push_back(VIterN);
                plan.push_back(VIterD);
            end
            plan.push_back(VDone);
            nxt = plan.pop_front();
        end else if (plan.size() > 0) begin
            nxt = plan.pop_front();
        end else begin
            nxt = VIdle;
        end
        cur_idle = (nxt == VIdle);
        exp_q.push_back(nxt);
    endtask

    task automatic step(input logic r, input logic s);
        reset = r;
        start = s;
        model_step(r, s);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            logic [8:0] act, exp_v;
            act = {busy, done, sel_muxa, sel_muxb, enA, enB, enC};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow cyc=%0d actual=%b required=<entry>", cyc, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, exp_v);
                end
            end
            if (b2b_en && done === 1'b1) begin
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc - last_done != int'(Period)) begin
                        n_bad++;
                        $display("FAIL b2b_spacing actual=%0d required=%0d",
                                 cyc - last_done, Period);
                    end
                end
                last_done = cyc;
            end
        end
    end

    initial begin
        int ndone;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cur_idle = 1'b1;
        exp_q.push_back(VIdle);
        mon_en = 1'b1;

        // Collision: reset and start together must leave the FSM idle.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Isolated run, then reset mid-ITER_D held two cycles, then quiet.
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

        // Start toggled every cycle while busy.
        for (int i = 0; i < 2 * int'(Period); i++) step(1'b0, 1'(i % 2 == 0));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Back-to-back with start held high.
        b2b_en = 1'b1;
        for (int i = 0; i < 6 * int'(Period); i++) step(1'b0, 1'b1);
        b2b_en = 1'b0;
        step(1'b0, 1'b0);
        for (int i = 0; i < int'(Period); i++) step(1'b0, 1'b0);

        // Randomised start/reset traffic.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < int'(Period); i++) step(1'b0, 1'b0);

        @(negedge clock);
        #1;
        mon_en = 1'b0;
        ndone = (last_done < 0) ? 0 : 1;
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL b2b_seen actual=%0d required=1", ndone);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
